// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcode constants, ALU
// function codes, immediate-extension encodings, FSM states and the
// instruction classes produced by the opcode decoder.
package multicycle_ctrl_pkg;

  // Opcode field Instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  // ALU function codes understood by the datapath ALU
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Immediate extension modes driven to the immediate unit
  localparam logic [1:0] IMM_SEXT    = 2'b00;
  localparam logic [1:0] IMM_ZEXT    = 2'b01;
  localparam logic [1:0] IMM_SHL16   = 2'b10;
  localparam logic [1:0] IMM_SEXT_S2 = 2'b11;

  // Controller states, 4-bit binary encoding
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_BRANCH   = 4'd5,
    S_JUMP     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_WB_ALU   = 4'd11
  } state_e;

  // Instruction classes; each class selects one execution path of the FSM
  typedef enum logic [2:0] {
    CL_ILLEGAL = 3'd0,
    CL_RTYPE   = 3'd1,
    CL_ITYPE   = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_JUMP    = 3'd4,
    CL_LOAD    = 3'd5,
    CL_STORE   = 3'd6
  } class_e;

  // beq takes the branch on Zero, bne on its complement
  function automatic logic branchTaken(input logic isBne, input logic zero);
    return zero ^ isBne;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle controller and the datapath.
// The controller is the master: it consumes the fetched opcode, the ALU
// Zero flag and the stall request, and drives every datapath control line.
interface multicycle_ctrl_if #(
  parameter int FUNC_W = 4
);

  logic [5:0]        Opcode;
  logic [3:0]        Func;
  logic              Zero;
  logic              Stall;
  logic              PC_sel;
  logic              PC_LdEn;
  logic              IR_LdEn;
  logic              RF_WrEn;
  logic              RF_WrData_sel;
  logic              RF_B_sel;
  logic              ALU_Bin_sel;
  logic [FUNC_W-1:0] ALU_func;
  logic [1:0]        ImmExt;
  logic              MEM_WrEn;
  logic              ByteOp;
  logic              Illegal;

  modport master (
    input  Opcode, Func, Zero, Stall,
    output PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
           ALU_Bin_sel, ALU_func, ImmExt, MEM_WrEn, ByteOp, Illegal
  );

  modport slave (
    output Opcode, Func, Zero, Stall,
    input  PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
           ALU_Bin_sel, ALU_func, ImmExt, MEM_WrEn, ByteOp, Illegal
  );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode decoder: maps Opcode/Func to the instruction class
// and to the ALU function, immediate mode and access size that the class's
// execution states will drive.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int FUNC_W = 4
) (
  input  logic [5:0]        i_opcode,
  input  logic [3:0]        i_func,
  output class_e            o_class,
  output logic              o_isBne,
  output logic [FUNC_W-1:0] o_aluFunc,
  output logic [1:0]        o_immExt,
  output logic              o_byteOp
);

  // Unknown opcodes fall through to CL_ILLEGAL with neutral controls
  always_comb begin
    o_class   = CL_ILLEGAL;
    o_isBne   = 1'b0;
    o_aluFunc = FUNC_W'(ALU_ADD);
    o_immExt  = IMM_SEXT;
    o_byteOp  = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_class   = CL_RTYPE;
        o_aluFunc = FUNC_W'(i_func);
      end
      OP_ADDI, OP_LI: begin
        o_class = CL_ITYPE;
      end
      OP_ANDI: begin
        o_class   = CL_ITYPE;
        o_aluFunc = FUNC_W'(ALU_AND);
        o_immExt  = IMM_ZEXT;
      end
      OP_ORI: begin
        o_class   = CL_ITYPE;
        o_aluFunc = FUNC_W'(ALU_OR);
        o_immExt  = IMM_ZEXT;
      end
      OP_LUI: begin
        o_class  = CL_ITYPE;
        o_immExt = IMM_SHL16;
      end
      OP_BEQ, OP_BNE: begin
        o_class   = CL_BRANCH;
        o_isBne   = (i_opcode == OP_BNE);
        o_aluFunc = FUNC_W'(ALU_SUB);
        o_immExt  = IMM_SEXT_S2;
      end
      OP_B: begin
        o_class  = CL_JUMP;
        o_immExt = IMM_SEXT_S2;
      end
      OP_LB, OP_LW: begin
        o_class  = CL_LOAD;
        o_byteOp = (i_opcode == OP_LB);
      end
      OP_SB, OP_SW: begin
        o_class  = CL_STORE;
        o_byteOp = (i_opcode == OP_SB);
      end
      default: begin
        o_class = CL_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/execute controller. The state register and the
// per-instruction decode results captured in S_DECODE live here; control
// lines are decoded from the registered state. Stall freezes the state and
// masks every write/load enable while leaving the mux selects untouched.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int FUNC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  state_e            r_state;
  class_e            r_class;
  logic              r_isBne;
  logic [FUNC_W-1:0] r_aluFunc;
  logic [1:0]        r_immExt;
  logic              r_byteOp;

  class_e            w_class;
  logic              w_isBne;
  logic [FUNC_W-1:0] w_aluFunc;
  logic [1:0]        w_immExt;
  logic              w_byteOp;

  logic w_pcSel;
  logic w_pcLdEn;
  logic w_irLdEn;
  logic w_rfWrEn;
  logic w_rfWrDataSel;
  logic w_rfBSel;
  logic w_aluBinSel;
  logic w_memWrEn;
  logic w_byteOpOut;
  logic w_illegal;

  multicycle_ctrl_decode #(
    .FUNC_W (FUNC_W)
  ) u_decode (
    .i_opcode  (bus.Opcode),
    .i_func    (bus.Func),
    .o_class   (w_class),
    .o_isBne   (w_isBne),
    .o_aluFunc (w_aluFunc),
    .o_immExt  (w_immExt),
    .o_byteOp  (w_byteOp)
  );

  // State sequencing plus capture of the decoded instruction in S_DECODE;
  // nothing advances while Stall is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RESET;
      r_class   <= CL_ILLEGAL;
      r_isBne   <= 1'b0;
      r_aluFunc <= '0;
      r_immExt  <= IMM_SEXT;
      r_byteOp  <= 1'b0;
    end else if (!bus.Stall) begin
      case (r_state)
        S_RESET:  r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_class   <= w_class;
          r_isBne   <= w_isBne;
          r_aluFunc <= w_aluFunc;
          r_immExt  <= w_immExt;
          r_byteOp  <= w_byteOp;
          case (w_class)
            CL_RTYPE:  r_state <= S_EXEC_R;
            CL_ITYPE:  r_state <= S_EXEC_I;
            CL_BRANCH: r_state <= S_BRANCH;
            CL_JUMP:   r_state <= S_JUMP;
            CL_LOAD,
            CL_STORE:  r_state <= S_MEM_ADDR;
            default:   r_state <= S_FETCH;
          endcase
        end
        S_EXEC_R,
        S_EXEC_I:   r_state <= S_WB_ALU;
        S_MEM_ADDR: r_state <= (r_class == CL_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   r_state <= S_WB_MEM;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Per-state control decode; the only live inputs used are the opcode in
  // S_DECODE (to flag an illegal instruction) and Zero in S_BRANCH
  always_comb begin
    w_pcSel       = 1'b0;
    w_pcLdEn      = 1'b0;
    w_irLdEn      = 1'b0;
    w_rfWrEn      = 1'b0;
    w_rfWrDataSel = 1'b0;
    w_rfBSel      = 1'b0;
    w_aluBinSel   = 1'b0;
    w_memWrEn     = 1'b0;
    w_byteOpOut   = 1'b0;
    w_illegal     = 1'b0;
    case (r_state)
      S_DECODE: begin
        w_irLdEn = 1'b1;
        if (w_class == CL_ILLEGAL) begin
          w_illegal = 1'b1;
          w_pcLdEn  = 1'b1;
        end
      end
      S_EXEC_I,
      S_MEM_ADDR: w_aluBinSel = 1'b1;
      S_WB_ALU: begin
        w_rfWrEn = 1'b1;
        w_pcLdEn = 1'b1;
        w_rfBSel = (r_class == CL_ITYPE);
      end
      S_BRANCH: begin
        w_rfBSel = 1'b1;
        w_pcLdEn = 1'b1;
        w_pcSel  = branchTaken(r_isBne, bus.Zero);
      end
      S_JUMP: begin
        w_pcLdEn = 1'b1;
        w_pcSel  = 1'b1;
      end
      S_MEM_RD: w_byteOpOut = r_byteOp;
      S_WB_MEM: begin
        w_rfWrEn      = 1'b1;
        w_rfWrDataSel = 1'b1;
        w_pcLdEn      = 1'b1;
      end
      S_MEM_WR: begin
        w_memWrEn   = 1'b1;
        w_rfBSel    = 1'b1;
        w_pcLdEn    = 1'b1;
        w_byteOpOut = r_byteOp;
      end
      default: begin
        w_pcSel = 1'b0;
      end
    endcase
  end

  // Stall masks the enables only; selects keep steering the held operation
  always_comb begin
    bus.PC_LdEn       = w_pcLdEn  & ~bus.Stall;
    bus.IR_LdEn       = w_irLdEn  & ~bus.Stall;
    bus.RF_WrEn       = w_rfWrEn  & ~bus.Stall;
    bus.MEM_WrEn      = w_memWrEn & ~bus.Stall;
    bus.Illegal       = w_illegal & ~bus.Stall;
    bus.PC_sel        = w_pcSel;
    bus.RF_WrData_sel = w_rfWrDataSel;
    bus.RF_B_sel      = w_rfBSel;
    bus.ALU_Bin_sel   = w_aluBinSel;
    bus.ByteOp        = w_byteOpOut;
    bus.ALU_func      = r_aluFunc;
    bus.ImmExt        = r_immExt;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the instruction-fetch/execute datapath of the single-issue processor.
- Sequences the PC register load enable and next-PC select (PC+4 vs PC+4+immediate), instruction register capture, register-file write, ALU operand/function selection and data-memory access.
- Sits beside the datapath; its only inputs are the fetched opcode, the ALU Zero flag and an external stall.

Parameters:
- FUNC_W, 4, width of ALU function code driven to the ALU.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; forces FSM to S_RESET.
- Opcode  in  6  Instr[31:26] from instruction memory (synchronous read, valid one cycle after PC changes).
- Func  in  4  Instr[3:0], R-type ALU function.
- Zero  in  1  ALU equality flag, valid in S_BRANCH.
- Stall  in  1  external hold; freezes FSM in current state, all write enables 0.
- PC_sel  out  1  0 = PC+4, 1 = PC+4+PC_Immed.
- PC_LdEn  out  1  PC register load enable.
- IR_LdEn  out  1  instruction register capture.
- RF_WrEn  out  1  register-file write enable.
- RF_WrData_sel  out  1  0 = ALU result, 1 = memory data.
- RF_B_sel  out  1  0 = rt field, 1 = rd field.
- ALU_Bin_sel  out  1  0 = register B, 1 = immediate.
- ALU_func  out  FUNC_W  ALU operation.
- ImmExt  out  2  00 sign-ext, 01 zero-ext, 10 shift-left-16, 11 sign-ext<<2.
- MEM_WrEn  out  1  data-memory write enable.
- ByteOp  out  1  1 = byte access (lb/sb).
- Illegal  out  1  one-cycle pulse on unknown opcode.

Behaviour:
- Async Reset -> state S_RESET; all outputs 0 (ALU_func 0, ImmExt 00). S_RESET -> S_FETCH on the first clock after Reset deasserts; PC is not loaded in S_RESET.
- Outputs are Moore (decoded from the registered state) except ALU_func/ImmExt/ByteOp, which decode from Opcode/Func registered at S_DECODE.
- S_FETCH: IMEM reads the current PC; all enables 0. -> S_DECODE.
- S_DECODE: IR_LdEn=1; Opcode latched internally.
  - R-type 100000 -> S_EXEC_R.
  - addi 110000 / andi 110010 / ori 110011 / li 111000 / lui 111001 -> S_EXEC_I.
  - beq 000000 / bne 000001 -> S_BRANCH.
  - b 111111 -> S_JUMP.
  - lb 000011 / lw 001111 / sb 000111 / sw 011111 -> S_MEM_ADDR.
  - Otherwise -> S_FETCH with Illegal=1, PC_LdEn=1, PC_sel=0 (skip instruction).
- S_EXEC_R: ALU_Bin_sel=0, ALU_func=Func. -> S_WB_ALU.
- S_EXEC_I: ALU_Bin_sel=1.
  - addi/li: ALU_func=add; ImmExt 00.
  - andi: ALU_func=and; ImmExt 01.
  - ori: ALU_func=or; ImmExt 01.
  - lui: ALU_func=add; ImmExt 10.
  - -> S_WB_ALU.
- S_WB_ALU: RF_WrEn=1, RF_WrData_sel=0, PC_LdEn=1, PC_sel=0; RF_B_sel=1 for I-type. -> S_FETCH.
- S_BRANCH: ALU_Bin_sel=0, ALU_func=sub, RF_B_sel=1, ImmExt 11, PC_LdEn=1.
  - PC_sel = Zero for beq, ~Zero for bne.
  - -> S_FETCH.
- S_JUMP: ImmExt 11, PC_LdEn=1, PC_sel=1. -> S_FETCH.
- S_MEM_ADDR: ALU_Bin_sel=1, ALU_func=add, ImmExt 00. -> S_MEM_RD for loads, S_MEM_WR for stores.
- S_MEM_RD: memory read; ByteOp per opcode. -> S_WB_MEM.
- S_WB_MEM: RF_WrEn=1, RF_WrData_sel=1, PC_LdEn=1, PC_sel=0. -> S_FETCH.
- S_MEM_WR: MEM_WrEn=1, RF_B_sel=1, PC_LdEn=1, PC_sel=0. -> S_FETCH.
- Invariant: PC_LdEn is asserted exactly once per instruction, in its final state.
- CPI: ALU 4, branch/jump 3, store 4, load 5, illegal 2.
- Stall=1:
  - State held; PC_LdEn, RF_WrEn, MEM_WrEn, IR_LdEn, Illegal forced 0.
  - Muxes keep their values.
  - Operation resumes in the same state when Stall drops.
- Reset mid-instruction aborts immediately; no partial write is issued after Reset rises.
- PC wrap-around is a datapath concern (32-bit modulo); the controller does not check it.

Decomposition:
- Shared package/header `ctrl_defs` holds:
  - opcode constants;
  - ALU function codes (add=0000, sub=0001, and=0010, or=0011);
  - ImmExt encodings;
  - state encodings (4-bit, binary).
- Natural sub-module: `ctrl_decode`, the combinational opcode -> {class, ALU_func, ImmExt, ByteOp} decoder. FSM next-state and output registers live in the top.

Test Plan:
- Reset asserted mid-S_EXEC_R -> all outputs 0 immediately (async); S_FETCH one clock after release; no RF_WrEn pulse.
- R-type add (Opcode 100000, Func 0000) -> IR_LdEn cycle 2, ALU_func 0000 cycle 3, RF_WrEn+PC_LdEn with PC_sel=0 cycle 4, back to fetch cycle 5.
- beq with Zero=1 -> PC_LdEn=1, PC_sel=1 in cycle 3; repeat with Zero=0 -> PC_sel=0; bne inverts both.
- lw 001111 -> states FETCH, DECODE, MEM_ADDR, MEM_RD, WB_MEM; RF_WrData_sel=1 and RF_WrEn=1 only in cycle 5; sb 000111 -> MEM_WrEn=1 and ByteOp=1 in cycle 4 only.
- Stall held 3 cycles during S_MEM_WR -> MEM_WrEn=0 while stalled, single MEM_WrEn/PC_LdEn pulse after release.
- Opcode 101010 -> Illegal pulse plus PC_LdEn with PC_sel=0 in DECODE cycle, next state S_FETCH, no RF/MEM writes.
